textbuffer_scroll: RTL and testbench

Parametrised text-mode frame buffer, the successor to the fixed 20x15 text buffer. It holds character and attribute RAM with configurable column/row counts and a CPU-visible register window. It adds vsync-latched hardware row scrolling, a hardware clear engine with a busy flag, and a fixed-latency pixel pipeline. It sits between the CPU bus and the video timing generator and drives the 4-bit palette index to the video DAC path.

---
 rtl/textbuffer_pkg.sv | 22 ++
 rtl/textbuffer_if.sv | 20 ++
 rtl/font_cp437_8x8.sv | 23 ++
 rtl/textbuffer_clear_fsm.sv | 73 +++++++
 rtl/textbuffer_scroll.sv | 189 ++++++++++++++++++
 tb/tb_textbuffer_scroll.sv | 218 +++++++++++++++++++++
 6 files changed

// File: rtl/textbuffer_pkg.sv
// Shared constants, clear-engine state type and sizing helper
// for the scrolling text frame buffer.
package textbuffer_pkg;

    localparam int OFF_SCROLL = 0;
    localparam int OFF_CLEAR  = 1;
    localparam int OFF_STATUS = 2;
    localparam int OFF_CURCOL = 3;
    localparam int OFF_CURROW = 4;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_e;

    function automatic int cell_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/textbuffer_if.sv
// CPU-side bus of the text frame buffer: address, strobes,
// write/read data and the clear-engine busy flag.
interface textbuffer_if;
    logic [15:0] addr;
    logic        we;
    logic        oe;
    logic [7:0]  di;
    logic [7:0]  dout;
    logic        busy;

    modport master (
        output addr, we, oe, di,
        input  dout, busy
    );

    modport slave (
        input  addr, we, oe, di,
        output dout, busy
    );
endinterface

// File: rtl/font_cp437_8x8.sv
// 8x8 CP437 glyph ROM, one registered row per access (addr = char*8 + line).
// Populated with the glyphs the display currently uses; others render blank.
module font_cp437_8x8 (
    input  logic        clk,
    input  logic [10:0] addr_i,
    output logic [7:0]  data_o
);
    logic [63:0] glyph;

    always_comb begin
        glyph = '0;
        unique case (addr_i[10:3])
            8'h41:   glyph = 64'h3078_CCCC_FCCC_CC00;
            8'h42:   glyph = 64'hFC66_667C_6666_FC00;
            8'hDB:   glyph = 64'hFFFF_FFFF_FFFF_FFFF;
            default: glyph = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        data_o <= glyph[{~addr_i[2:0], 3'b000} +: 8];
    end
endmodule

// File: rtl/textbuffer_clear_fsm.sv
// Clear engine: fills every cell with a blank and a fill attribute,
// and arbitrates the single RAM write port against CPU writes.
module textbuffer_clear_fsm
    import textbuffer_pkg::*;
#(
    parameter int N  = 300,
    parameter int IW = cell_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [7:0]    fill_i,
    input  logic          cpu_we_char_i,
    input  logic          cpu_we_attr_i,
    input  logic [IW-1:0] cpu_idx_i,
    input  logic [7:0]    cpu_data_i,
    output logic          busy_o,
    output logic          char_we_o,
    output logic          attr_we_o,
    output logic [IW-1:0] idx_o,
    output logic [7:0]    char_o,
    output logic [7:0]    attr_o
);
    clr_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    fill_q, fill_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fill_d    = fill_q;
        char_we_o = 1'b0;
        attr_we_o = 1'b0;
        idx_o     = cpu_idx_i;
        char_o    = cpu_data_i;
        attr_o    = cpu_data_i;
        unique case (state_q)
            IDLE: begin
                char_we_o = cpu_we_char_i;
                attr_we_o = cpu_we_attr_i;
                if (start_i) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                    fill_d  = fill_i;
                end
            end
            CLEAR: begin
                char_we_o = 1'b1;
                attr_we_o = 1'b1;
                idx_o     = idx_q;
                char_o    = BLANK_CHAR;
                attr_o    = fill_q;
                if (idx_q == IW'(N - 1)) state_d = IDLE;
                else idx_d = idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == CLEAR);
endmodule

// File: rtl/textbuffer_scroll.sv
// Text frame buffer with vsync-latched row scroll, clear engine and 3-stage pixel path.
// Define TEXTBUFFER_CURSOR_EN to build the blinking hardware cursor.
module textbuffer_scroll
    import textbuffer_pkg::*;
#(
    parameter int          COLS     = 20,
    parameter int          ROWS     = 15,
    parameter logic [15:0] BASEADDR = 16'h0400,
    parameter int          HPOS_W   = 8,
    parameter int          VPOS_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    textbuffer_if.slave       bus,
    input  logic [HPOS_W-1:0] hpos,
    input  logic [VPOS_W-1:0] vpos,
    input  logic              vsync,
    output logic [3:0]        color
);
    localparam int          N     = COLS * ROWS;
    localparam int          IW    = cell_w(N);
    localparam logic [15:0] N_W   = 16'(N);
    localparam logic [15:0] R_W   = 16'(2 * N);
    localparam logic [7:0]  ROWS8 = 8'(ROWS);
    localparam logic [7:0]  COLS8 = 8'(COLS);

    logic [7:0] char_mem [N];
    logic [7:0] attr_mem [N];

    logic [15:0]   off;
    logic          in_win, hit_char, hit_attr, hit_scroll, hit_clear;
    logic          hit_status, hit_ccol, hit_crow;
    logic [IW-1:0] cpu_idx;

    assign off        = bus.addr - BASEADDR;
    assign in_win     = (bus.addr >= BASEADDR) && (off < R_W + 16'd5);
    assign hit_char   = in_win && (off < N_W);
    assign hit_attr   = in_win && (off >= N_W) && (off < R_W);
    assign hit_scroll = in_win && (off == R_W + 16'(OFF_SCROLL));
    assign hit_clear  = in_win && (off == R_W + 16'(OFF_CLEAR));
    assign hit_status = in_win && (off == R_W + 16'(OFF_STATUS));
    assign hit_ccol   = in_win && (off == R_W + 16'(OFF_CURCOL));
    assign hit_crow   = in_win && (off == R_W + 16'(OFF_CURROW));
    assign cpu_idx    = hit_char ? IW'(off) : IW'(off - N_W);

    logic          busy, ram_we_char, ram_we_attr;
    logic [IW-1:0] ram_idx;
    logic [7:0]    ram_char, ram_attr;

    textbuffer_clear_fsm #(.N(N), .IW(IW)) u_clr (
        .clk          (clk),
        .reset        (reset),
        .start_i      (bus.we && hit_clear),
        .fill_i       (bus.di),
        .cpu_we_char_i(bus.we && hit_char),
        .cpu_we_attr_i(bus.we && hit_attr),
        .cpu_idx_i    (cpu_idx),
        .cpu_data_i   (bus.di),
        .busy_o       (busy),
        .char_we_o    (ram_we_char),
        .attr_we_o    (ram_we_attr),
        .idx_o        (ram_idx),
        .char_o       (ram_char),
        .attr_o       (ram_attr)
    );

    logic [7:0] scroll_shadow_q, scroll_active_q, dout_q, rdata;
    logic [7:0] cur_col_rd, cur_row_rd;
    logic       vsync_q, vs_rise, cur_d, blink_ph;

    assign vs_rise  = vsync && !vsync_q;
    assign bus.dout = dout_q;
    assign bus.busy = busy;

    // RAM reads are masked while the clear engine owns the write port.
    always_comb begin
        rdata = 8'h00;
        unique case (1'b1)
            hit_char:   rdata = busy ? 8'h00 : char_mem[cpu_idx];
            hit_attr:   rdata = busy ? 8'h00 : attr_mem[cpu_idx];
            hit_scroll: rdata = scroll_shadow_q;
            hit_status: rdata = {7'd0, busy};
            hit_ccol:   rdata = cur_col_rd;
            hit_crow:   rdata = cur_row_rd;
            default:    rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scroll_shadow_q <= '0;
            scroll_active_q <= '0;
            vsync_q         <= 1'b0;
            dout_q          <= '0;
        end else begin
            vsync_q <= vsync;
            if (bus.we && hit_scroll && (bus.di < ROWS8)) scroll_shadow_q <= bus.di;
            if (vs_rise) scroll_active_q <= scroll_shadow_q;
            if (bus.oe) dout_q <= rdata;
        end
    end

    logic [7:0]    hcol, vrow, row_sum, row;
    logic          vis_d;
    logic [IW-1:0] pix_cell;

    assign hcol     = 8'(hpos >> 3);
    assign vrow     = 8'(vpos >> 3);
    assign vis_d    = (hcol < COLS8) && (vrow < ROWS8);
    assign row_sum  = vrow + scroll_active_q;
    assign row      = (row_sum >= ROWS8) ? row_sum - ROWS8 : row_sum;
    assign pix_cell = vis_d ? IW'(16'(row) * 16'(COLS) + 16'(hcol)) : '0;

`ifdef TEXTBUFFER_CURSOR_EN
    logic [7:0] cur_col_q, cur_row_q;
    logic [4:0] blink_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_col_q <= '0;
            cur_row_q <= '0;
            blink_q   <= '0;
        end else begin
            if (bus.we && hit_ccol) cur_col_q <= bus.di;
            if (bus.we && hit_crow) cur_row_q <= bus.di;
            if (vs_rise) blink_q <= blink_q + 5'd1;
        end
    end

    assign cur_col_rd = cur_col_q;
    assign cur_row_rd = cur_row_q;
    assign cur_d      = (hcol == cur_col_q) && (vrow == cur_row_q);
    assign blink_ph   = blink_q[4];
`else
    assign cur_col_rd = 8'h00;
    assign cur_row_rd = 8'h00;
    assign cur_d      = 1'b0;
    assign blink_ph   = 1'b0;
`endif

    logic [7:0] s1_char_q, s1_attr_q, glyph_row;
    logic [2:0] s1_px_q, s1_line_q, s2_px_q;
    logic       s1_vis_q, s1_cur_q, s2_vis_q, s2_cur_q, lit;
    logic [3:0] s2_fg_q, s2_bg_q, color_q;

    always_ff @(posedge clk) begin
        if (ram_we_char) char_mem[ram_idx] <= ram_char;
        if (ram_we_attr) attr_mem[ram_idx] <= ram_attr;
        s1_char_q <= char_mem[pix_cell];
        s1_attr_q <= attr_mem[pix_cell];
    end

    font_cp437_8x8 u_font (
        .clk   (clk),
        .addr_i({s1_char_q, s1_line_q}),
        .data_o(glyph_row)
    );

    // Swapping fg/bg for the cursor is the same as inverting the glyph bit.
    assign lit = glyph_row[~s2_px_q] ^ (s2_cur_q && blink_ph);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_px_q   <= '0;
            s1_line_q <= '0;
            s1_vis_q  <= 1'b0;
            s1_cur_q  <= 1'b0;
            s2_px_q   <= '0;
            s2_vis_q  <= 1'b0;
            s2_cur_q  <= 1'b0;
            s2_fg_q   <= '0;
            s2_bg_q   <= '0;
            color_q   <= '0;
        end else begin
            s1_px_q   <= hpos[2:0];
            s1_line_q <= vpos[2:0];
            s1_vis_q  <= vis_d;
            s1_cur_q  <= cur_d;
            s2_px_q   <= s1_px_q;
            s2_vis_q  <= s1_vis_q;
            s2_cur_q  <= s1_cur_q;
            s2_fg_q   <= s1_attr_q[3:0];
            s2_bg_q   <= s1_attr_q[7:4];
            color_q   <= !s2_vis_q ? 4'h0 : (lit ? s2_fg_q : s2_bg_q);
        end
    end

    assign color = color_q;
endmodule

// File: tb/tb_textbuffer_scroll.sv
// Directed bench for textbuffer_scroll (20x15, base 0x0400).
// Cursor checks are built only with TEXTBUFFER_CURSOR_EN.
module tb_textbuffer_scroll;
    localparam logic [15:0] SCROLL = 16'h0658;
    localparam logic [15:0] CLR    = 16'h0659;
    localparam logic [15:0] STATUS = 16'h065A;
    localparam logic [15:0] CURCOL = 16'h065B;
    localparam logic [15:0] CURROW = 16'h065C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] hpos = '0;
    logic [6:0] vpos = '0;
    logic       vsync = 1'b0;
    logic [3:0] color;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] d;
    int         cnt, bad_c, bad_a;

    textbuffer_if bus();

    textbuffer_scroll dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus),
        .hpos (hpos),
        .vpos (vpos),
        .vsync(vsync),
        .color(color)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] v);
        @(negedge clk);
        bus.addr = a; bus.di = v; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [7:0] v);
        @(negedge clk);
        bus.addr = a; bus.oe = 1'b1;
        @(negedge clk);
        bus.oe = 1'b0;
        v = bus.dout;
    endtask

    task automatic pix(input string tag, input logic [7:0] h, input logic [6:0] v,
                       input logic [3:0] exp);
        @(negedge clk);
        hpos = h; vpos = v;
        repeat (3) @(negedge clk);
        chk(tag, color, exp);
    endtask

    task automatic vs_pulse();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
    endtask

    function automatic logic [3:0] a_pix(input int p);
        logic [7:0] r;
        r = 8'h30;
        return r[7-p] ? 4'hE : 4'h1;
    endfunction

    initial begin
        bus.addr = '0; bus.we = 1'b0; bus.oe = 1'b0; bus.di = '0;
        repeat (3) @(negedge clk);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_color", color, 4'h0);
        chk("rst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;

        // 'A' in fg E / bg 1 at cell 0, swept with 3-cycle latency
        cpu_wr(16'h0400, 8'h41);
        cpu_wr(16'h052C, 8'h1E);
        hpos = 8'd200; vpos = '0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            if (k == 2) chk("t1_lat", color, 4'h0);
            if (k >= 3) chk("t1_px", color, a_pix(k - 3));
            hpos = (k < 8) ? 8'(k) : 8'd200;
            @(negedge clk);
        end

        // Window edges and read-during-write
        cpu_rd(16'h0400, d);  chk("t5_char0", d, 8'h41);
        cpu_rd(16'h0000, d);  chk("t5_low", d, 8'h00);
        cpu_rd(16'h052C, d);  chk("t5_attr0", d, 8'h1E);
        cpu_rd(16'h0700, d);  chk("t5_high", d, 8'h00);
        cpu_wr(16'h0657, 8'h9A);
        cpu_rd(16'h0657, d);  chk("t5_attr_last", d, 8'h9A);
        cpu_rd(16'h03FF, d);  chk("t5_below", d, 8'h00);
        cpu_wr(16'h0402, 8'h11);
        @(negedge clk);
        bus.addr = 16'h0402; bus.di = 8'h22; bus.we = 1'b1; bus.oe = 1'b1;
        @(negedge clk);
        bus.we = 1'b0; bus.oe = 1'b0;
        chk("t5_rdw_old", bus.dout, 8'h11);
        cpu_rd(16'h0402, d);  chk("t5_rdw_new", d, 8'h22);
        bus.addr = 16'h0000;
        repeat (3) @(negedge clk);
        chk("t5_hold", bus.dout, 8'h22);

        // Scroll by 3, latched on vsync
        cpu_wr(16'h043C, 8'h42);
        cpu_wr(16'h0568, 8'h5C);
        cpu_wr(SCROLL, 8'd3);
        pix("t2_pre", 8'd2, 7'd0, 4'hE);
        cpu_rd(SCROLL, d);    chk("t2_shadow", d, 8'd3);
        vs_pulse();
        pix("t2_b0_2", 8'd2, 7'd0, 4'hC);
        pix("t2_b0_7", 8'd7, 7'd0, 4'h5);
        pix("t2_b1_0", 8'd0, 7'd1, 4'h5);
        pix("t2_b1_1", 8'd1, 7'd1, 4'hC);
        pix("t2_wrap", 8'd2, 7'd96, 4'hE);
        pix("t2_row_oob", 8'd2, 7'd120, 4'h0);
        pix("t2_col_oob", 8'd160, 7'd0, 4'h0);
        cpu_wr(SCROLL, 8'd15);
        cpu_rd(SCROLL, d);    chk("t2_ignore15", d, 8'd3);

        // Clear with attr 0x70
        cpu_wr(CLR, 8'h70);
        cnt = 0;
        while (bus.busy && cnt < 1000) begin
            case (cnt)
                10: begin bus.addr = 16'h0405; bus.di = 8'h99; bus.we = 1'b1; end
                20: begin bus.we = 1'b0; bus.addr = 16'h0400; bus.oe = 1'b1; end
                21: begin bus.oe = 1'b0; chk("t3_busy_rd", bus.dout, 8'h00); end
                30: begin bus.addr = SCROLL; bus.di = 8'd0; bus.we = 1'b1; end
                31: bus.we = 1'b0;
                40: begin bus.addr = STATUS; bus.oe = 1'b1; end
                41: begin bus.oe = 1'b0; chk("t3_status_busy", bus.dout, 8'h01); end
                50: begin bus.addr = CLR; bus.di = 8'h33; bus.we = 1'b1; end
                51: bus.we = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            cnt++;
        end
        bus.we = 1'b0; bus.oe = 1'b0;
        chk("t3_busy_len", cnt, 300);
        cpu_rd(STATUS, d);    chk("t3_status_idle", d, 8'h00);
        cpu_rd(SCROLL, d);    chk("t3_scroll_busy_wr", d, 8'h00);
        cpu_rd(16'h0405, d);  chk("t3_drop_wr", d, 8'h20);
        bad_c = 0; bad_a = 0;
        for (int i = 0; i < 300; i++) begin
            cpu_rd(16'h0400 + 16'(i), d); if (d !== 8'h20) bad_c++;
            cpu_rd(16'h052C + 16'(i), d); if (d !== 8'h70) bad_a++;
        end
        chk("t3_char_bad", bad_c, 0);
        chk("t3_attr_bad", bad_a, 0);
        vs_pulse();
        pix("t3_blank", 8'd2, 7'd0, 4'h7);

        // Reset 100 cycles into a clear
        cpu_wr(SCROLL, 8'd5);
        for (int i = 0; i < 300; i++) cpu_wr(16'h0400 + 16'(i), 8'hC3);
        cpu_rd(16'h0400, d);  chk("t4_fill", d, 8'hC3);
        cpu_wr(CLR, 8'h34);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4_busy", bus.busy, 1'b0);
        chk("t4_dout", bus.dout, 8'h00);
        chk("t4_color", color, 4'h0);
        @(negedge clk) rst_n = 1'b1;
        cpu_rd(SCROLL, d);    chk("t4_scroll", d, 8'h00);
        cpu_rd(16'h0400 + 16'd99, d);  chk("t4_cell99", d, 8'h20);
        cpu_rd(16'h0400 + 16'd100, d); chk("t4_cell100", d, 8'hC3);
        bad_c = 0; bad_a = 0;
        for (int i = 0; i < 300; i++) begin
            cpu_rd(16'h0400 + 16'(i), d); if (d !== ((i < 100) ? 8'h20 : 8'hC3)) bad_c++;
            cpu_rd(16'h052C + 16'(i), d); if (d !== ((i < 100) ? 8'h34 : 8'h70)) bad_a++;
        end
        chk("t4_char_bad", bad_c, 0);
        chk("t4_attr_bad", bad_a, 0);

`ifdef TEXTBUFFER_CURSOR_EN
        cpu_wr(16'h0416, 8'hDB);
        cpu_wr(16'h0542, 8'h1E);
        cpu_wr(CURCOL, 8'd2);
        cpu_wr(CURROW, 8'd1);
        cpu_rd(CURCOL, d);    chk("t6_curcol", d, 8'd2);
        for (int f = 0; f < 32; f++) begin
            pix("t6_cursor", 8'd19, 7'd8, (f >= 16) ? 4'h1 : 4'hE);
            if (f == 20) pix("t6_neighbor", 8'd27, 7'd8, 4'h3);
            vs_pulse();
        end
        pix("t6_wrap", 8'd19, 7'd8, 4'hE);
`else
        cpu_wr(CURCOL, 8'd2);
        cpu_rd(CURCOL, d);    chk("t6_curcol_off", d, 8'h00);
        cpu_wr(CURROW, 8'd1);
        cpu_rd(CURROW, d);    chk("t6_currow_off", d, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
